// File: rtl/bus_reg_bank_pkg.sv
// ============================================================================
// Module : bus_reg_bank_pkg
// Brief  : Shared MODE encodings and address-width helper for the register bank.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bus_reg_bank_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;

  // A single-entry bank still needs a 1-bit address port.
  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_reg_cell.sv
// ============================================================================
// Module : bus_reg_cell
// Brief  : One WIDTH-bit register with hold/load/increment/clear operations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_reg_cell
  import bus_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sel_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (sel_i) begin
      case (mode_i)
        MODE_LOAD: value_d = d_i;
        MODE_INC:  value_d = value_q + WIDTH'(1);
        MODE_CLR:  value_d = '0;
        default:   value_d = value_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign q_o = value_q;
  // An increment from this value carries out of the register.
  assign wrap_o = &value_q;

endmodule

`default_nettype wire

// File: rtl/bus_reg_bank.sv
// ============================================================================
// Module : bus_reg_bank
// Brief  : Bank of DEPTH operate-in-place registers with tristate read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_reg_bank
  import bus_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLR_bar,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    WA,
  input  logic [1:0]       MODE,
  input  logic [1:0]       G_bar,
  input  logic [AW-1:0]    RA,
  input  logic [1:0]       OE_bar,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             ZERO
);

  logic             exec;
  logic [DEPTH-1:0] sel;
  logic [DEPTH-1:0] wrap;
  logic [WIDTH-1:0] cell_q [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic             co_q;
  logic             co_d;

  assign exec = (G_bar == 2'b00) && (int'(WA) < DEPTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign sel[i] = exec && (WA == AW'(i));

    bus_reg_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .clk_i  (CLK),
      .rst_ni (CLR_bar),
      .sel_i  (sel[i]),
      .mode_i (MODE),
      .d_i    (D),
      .q_o    (cell_q[i]),
      .wrap_o (wrap[i])
    );
  end

  // Only increments can carry; every other executed operation clears CO.
  always_comb begin
    co_d = co_q;
    if (exec) begin
      co_d = (MODE == MODE_INC) && |(sel & wrap);
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_bar) begin
      co_q <= 1'b0;
    end else begin
      co_q <= co_d;
    end
  end

  // Out-of-range read addresses match no cell and fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RA == AW'(i)) begin
        rd_data = cell_q[i];
      end
    end
  end

  assign CO   = co_q;
  assign ZERO = (rd_data == '0);
  assign Q    = (OE_bar == 2'b00) ? rd_data : {WIDTH{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_bus_reg_bank.sv
// ============================================================================
// Module : tb_bus_reg_bank
// Brief  : Directed self-checking bench for bus_reg_bank (DEPTH 4 and 3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bus_reg_bank;

  logic       clk;
  logic       clr_bar;
  logic [7:0] d;
  logic [1:0] wa;
  logic [1:0] mode;
  logic [1:0] g_bar;
  logic [1:0] ra;
  logic [1:0] oe_bar;
  wire  [7:0] q4;
  wire  [7:0] q3;
  logic       co4;
  logic       zero4;
  logic       co3;
  logic       zero3;

  int checks = 0;
  int errors = 0;

  bus_reg_bank #(.WIDTH(8), .DEPTH(4)) dut4 (
    .CLK(clk), .CLR_bar(clr_bar), .D(d), .WA(wa), .MODE(mode), .G_bar(g_bar),
    .RA(ra), .OE_bar(oe_bar), .Q(q4), .CO(co4), .ZERO(zero4)
  );

  bus_reg_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
    .CLK(clk), .CLR_bar(clr_bar), .D(d), .WA(wa), .MODE(mode), .G_bar(g_bar),
    .RA(ra), .OE_bar(oe_bar), .Q(q3), .CO(co3), .ZERO(zero3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] a, input logic [1:0] m, input logic [7:0] v);
    wa    = a;
    mode  = m;
    d     = v;
    g_bar = 2'b00;
    tick();
    g_bar = 2'b11;
  endtask

  task automatic do_reset();
    clr_bar = 1'b0;
    tick();
    clr_bar = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] zz;
    zz = 8'hzz;
    do_reset();
    oe_bar = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i);
      #1;
      checks++;
      if (q4 !== 8'h00) begin
        errors++;
        $display("FAIL reset_q ra=%0d got=%h exp=00", i, q4);
      end
      checks++;
      if (zero4 !== 1'b1) begin
        errors++;
        $display("FAIL reset_zero ra=%0d got=%b exp=1", i, zero4);
      end
    end
    checks++;
    if (co4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_co got=%b exp=0", co4);
    end
    oe_bar = 2'b01;
    #1;
    checks++;
    if (q4 !== zz) begin
      errors++;
      $display("FAIL reset_oe01_hiz got=%h exp=zz", q4);
    end
    oe_bar = 2'b10;
    #1;
    checks++;
    if (q4 !== zz) begin
      errors++;
      $display("FAIL reset_oe10_hiz got=%h exp=zz", q4);
    end
    oe_bar = 2'b00;
  endtask

  task automatic test_load();
    logic [7:0] exp [4];
    exp = '{8'h00, 8'h00, 8'hA5, 8'h00};
    op(2'd2, 2'b01, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i);
      #1;
      checks++;
      if (q4 !== exp[i]) begin
        errors++;
        $display("FAIL load_reg%0d got=%h exp=%h", i, q4, exp[i]);
      end
    end
    ra = 2'd2;
    #1;
    checks++;
    if (zero4 !== 1'b0) begin
      errors++;
      $display("FAIL load_zero got=%b exp=0", zero4);
    end
  endtask

  task automatic test_inc_wrap();
    ra = 2'd1;
    op(2'd1, 2'b01, 8'hFE);
    op(2'd1, 2'b10, 8'h00);
    checks++;
    if (q4 !== 8'hFF || co4 !== 1'b0) begin
      errors++;
      $display("FAIL inc_first got=%h/co=%b exp=ff/co=0", q4, co4);
    end
    op(2'd1, 2'b10, 8'h00);
    checks++;
    if (q4 !== 8'h00 || co4 !== 1'b1 || zero4 !== 1'b1) begin
      errors++;
      $display("FAIL inc_wrap got=%h/co=%b/z=%b exp=00/co=1/z=1", q4, co4, zero4);
    end
    op(2'd1, 2'b00, 8'h77);
    checks++;
    if (q4 !== 8'h00 || co4 !== 1'b0) begin
      errors++;
      $display("FAIL hold_clears_co got=%h/co=%b exp=00/co=0", q4, co4);
    end
    ra = 2'd2;
    #1;
    checks++;
    if (q4 !== 8'hA5) begin
      errors++;
      $display("FAIL inc_other_hold got=%h exp=a5", q4);
    end
  endtask

  task automatic test_gating();
    ra = 2'd0;
    wa = 2'd0; mode = 2'b01; d = 8'h3C;
    g_bar = 2'b10;
    tick();
    g_bar = 2'b01;
    tick();
    g_bar = 2'b11;
    #1;
    checks++;
    if (q4 !== 8'h00) begin
      errors++;
      $display("FAIL gate_disabled got=%h exp=00", q4);
    end
    // Transient enable between edges must not reach state.
    @(negedge clk);
    g_bar = 2'b00;
    #1;
    g_bar = 2'b11;
    tick();
    checks++;
    if (q4 !== 8'h00) begin
      errors++;
      $display("FAIL gate_glitch got=%h exp=00", q4);
    end
    op(2'd2, 2'b11, 8'hFF);
    ra = 2'd2;
    #1;
    checks++;
    if (q4 !== 8'h00 || co4 !== 1'b0) begin
      errors++;
      $display("FAIL clear_op got=%h/co=%b exp=00/co=0", q4, co4);
    end
  endtask

  task automatic test_depth3();
    do_reset();
    op(2'd3, 2'b01, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i);
      #1;
      checks++;
      if (q3 !== 8'h00 || zero3 !== 1'b1) begin
        errors++;
        $display("FAIL d3_reg%0d got=%h/z=%b exp=00/z=1", i, q3, zero3);
      end
    end
    ra = 2'd3;
    #1;
    checks++;
    if (q4 !== 8'h3C) begin
      errors++;
      $display("FAIL d4_reg3_load got=%h exp=3c", q4);
    end
  endtask

  task automatic test_reset_dominates();
    op(2'd0, 2'b01, 8'h55);
    op(2'd1, 2'b01, 8'hFF);
    op(2'd1, 2'b10, 8'h00);
    checks++;
    if (co4 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_co got=%b exp=1", co4);
    end
    wa = 2'd0; mode = 2'b01; d = 8'hFF; g_bar = 2'b00;
    clr_bar = 1'b0;
    tick();
    clr_bar = 1'b1;
    g_bar = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ra = 2'(i);
      #1;
      checks++;
      if (q4 !== 8'h00) begin
        errors++;
        $display("FAIL rstdom_reg%0d got=%h exp=00", i, q4);
      end
    end
    checks++;
    if (co4 !== 1'b0) begin
      errors++;
      $display("FAIL rstdom_co got=%b exp=0", co4);
    end
  endtask

  task automatic test_back_to_back();
    op(2'd1, 2'b01, 8'h10);
    @(negedge clk);
    ra = 2'd1; wa = 2'd1; mode = 2'b10; g_bar = 2'b00;
    #1;
    checks++;
    if (q4 !== 8'h10) begin
      errors++;
      $display("FAIL rw_before got=%h exp=10", q4);
    end
    tick();
    g_bar = 2'b11;
    checks++;
    if (q4 !== 8'h11 || co4 !== 1'b0) begin
      errors++;
      $display("FAIL rw_after got=%h/co=%b exp=11/co=0", q4, co4);
    end
  endtask

  initial begin
    clr_bar = 1'b1;
    d       = 8'h00;
    wa      = 2'd0;
    mode    = 2'b00;
    g_bar   = 2'b11;
    ra      = 2'd0;
    oe_bar  = 2'b00;
    @(negedge clk);
    test_reset();
    test_load();
    test_inc_wrap();
    test_gating();
    test_depth3();
    test_reset_dominates();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_reg_bank.md
BUS_REG_BANK -- requirements
Module: bus_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each register, of D and of Q; legal range 1..32.
REQ-002 Parameter DEPTH, default 4: number of registers in the bank; legal range 1..16.
REQ-003 Derived localparam AW = max(1, ceil(log2(DEPTH))): width of both address ports.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 CLR_bar  input  1  reset, synchronous and active-low.
REQ-006 D  input  WIDTH  load data.
REQ-007 WA  input  AW  write/operate address.
REQ-008 MODE  input  2  operation on the addressed register: 00 hold, 01 load, 10 increment, 11 clear.
REQ-009 G_bar  input  2  operation enables, active-low; an operation executes only when both bits are 0.
REQ-010 RA  input  AW  read address.
REQ-011 OE_bar  input  2  output enables, active-low; Q is driven only when both bits are 0.
REQ-012 Q  output  WIDTH  tristate read data.
REQ-013 CO  output  1  registered carry flag from the last executed operation.
REQ-014 ZERO  output  1  combinational flag: register at RA equals 0.

Function
REQ-015 An operation executes at a rising CLK edge only when CLR_bar=1, G_bar=2'b00 and WA<DEPTH; otherwise every register and CO hold.
REQ-016 MODE 00 leaves the addressed register unchanged and clears CO.
REQ-017 MODE 01 writes D into the addressed register and clears CO.
REQ-018 MODE 10 writes (reg+1) mod 2^WIDTH; CO is set to 1 iff the pre-increment value was all ones, else 0.
REQ-019 MODE 11 writes 0 into the addressed register and clears CO.
REQ-020 Only the register at WA changes; all other registers hold.
REQ-021 Q is high-impedance on all bits whenever OE_bar != 2'b00.
REQ-022 With OE_bar = 2'b00, Q = bank[RA] when RA<DEPTH, and Q = 0 when RA>=DEPTH.
REQ-023 The read path is combinational with no clock latency; an operation taken at edge N is visible on Q and ZERO immediately after edge N.
REQ-024 With RA==WA in the same cycle, Q shows the pre-edge value until the edge.
REQ-025 ZERO = 1 iff the value selected per REQ-022 is 0; ZERO is independent of OE_bar.
REQ-026 Changes on G_bar, MODE, D or WA between edges have no effect on state.

Reset
REQ-027 At a rising CLK edge with CLR_bar=0, all DEPTH registers become 0 and CO becomes 0.
REQ-028 Reset dominates G_bar and MODE, and an operation in progress is discarded.
REQ-029 CLR_bar has no asynchronous effect; state changes only at CLK edges.
REQ-030 During reset, Q still follows REQ-021/REQ-022, so it reads 0 or high-Z after the reset edge.

Structure
REQ-031 MODE encodings (MODE_HOLD, MODE_LOAD, MODE_INC, MODE_CLR) live in a shared include file used by this block and the sequencer.
REQ-032 One sub-module, bus_reg_cell, holds a single WIDTH-bit register with hold/load/inc/clear, its select input and its wrap output; it is instantiated DEPTH times.
REQ-033 Read mux, CO register and tristate driver live in bus_reg_bank; there is no other hierarchy.

Verification
Directed scenarios use WIDTH=8, DEPTH=4.
REQ-034 Reset, then OE_bar=00 with RA=0..3 -> Q=8'h00 and ZERO=1 for each; then OE_bar=01 -> Q all z.
REQ-035 G_bar=00, MODE=01, WA=2, D=8'hA5 for one edge -> Q=8'hA5 at RA=2 and registers 0, 1 and 3 still read 8'h00.
REQ-036 Load 8'hFE into reg 1, then MODE=10 for two edges -> value 8'hFF with CO=0, then 8'h00 with CO=1 and ZERO=1; next MODE=00 edge -> CO=0.
REQ-037 MODE=01, D=8'h3C with G_bar=10 or 01 -> no register changes; WA=3 with DEPTH=3 variant -> no change; RA=3 in that variant -> Q=8'h00.
REQ-038 Load 8'h55 into reg 0, then hold CLR_bar=0 together with G_bar=00, MODE=01, D=8'hFF for one edge -> all registers 8'h00 and CO=0.
REQ-039 RA=WA=1 with reg 1 at 8'h10, MODE=10 -> Q reads 8'h10 before the edge and 8'h11 after it.
